// File: rtl/pipeline_hazard_controller.sv
// Stall/flush arbiter for the dual-issue 5-stage pipeline.
// Drives per-stage register enables and bubble-insert controls from hazard,
// memory, branch and exception requests. Tracks the post-exception drain, a
// stall-length deadlock watchdog and optional performance counters.
// Optional build macro: HAZARD_PERF_CNT_EN (enables stall_cycles/flush_count).
module pipeline_hazard_controller #(
    parameter int unsigned STALL_TIMEOUT = 16,
    parameter int unsigned FLUSH_CYCLES  = 2,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_stall_req,
    input  logic             ex_stall_req,
    input  logic             mem_busy,
    input  logic             branch_redirect,
    input  logic             exception_req,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic             deadlock_err
);

    localparam int unsigned RUN_W = $clog2(STALL_TIMEOUT + 1);
    localparam int unsigned FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STALL_TIMEOUT);
    localparam logic [FC_W-1:0]  FC_INIT = FC_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [FC_W-1:0]  fcnt_q, fcnt_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             err_q, err_d;
    logic             flush_evt;

    // Control state, flush drain counter and watchdog registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            fcnt_q  <= '0;
            run_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            run_q   <= run_d;
            err_q   <= err_d;
        end
    end

    // Priority arbitration: enables, flushes, reported state and next state
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        ctrl_state   = ST_RUN;
        state_d      = ST_RUN;
        fcnt_d       = fcnt_q;
        flush_evt    = 1'b0;

        if (reset) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (mem_busy) begin
            pc_en      = 1'b0;
            if_id_en   = 1'b0;
            id_ex_en   = 1'b0;
            ex_mem_en  = 1'b0;
            mem_wb_en  = 1'b0;
            // Frozen: keep an in-progress drain exactly where it is
            if (state_q == ST_FLUSH) begin
                ctrl_state = ST_FLUSH;
                state_d    = ST_FLUSH;
            end else begin
                ctrl_state = ST_STALL;
                state_d    = ST_STALL;
            end
        end else if (exception_req) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            ctrl_state   = (state_q == ST_FLUSH) ? ST_FLUSH : ST_RUN;
            state_d      = ST_FLUSH;
            fcnt_d       = FC_INIT;
            flush_evt    = 1'b1;
        end else if (state_q == ST_FLUSH) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            ctrl_state  = ST_FLUSH;
            if (fcnt_q == '0) begin
                state_d = ST_RUN;
            end else begin
                state_d = ST_FLUSH;
                fcnt_d  = fcnt_q - FC_W'(1);
            end
        end else if (ex_stall_req) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
            ctrl_state   = ST_STALL;
            state_d      = ST_STALL;
        end else if (branch_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_evt   = 1'b1;
        end else if (id_stall_req) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            ctrl_state  = ST_STALL;
            state_d     = ST_STALL;
        end
    end

    // Watchdog: saturating run length of consecutive frozen-PC cycles
    always_comb begin
        run_d = run_q;
        err_d = err_q;
        if (pc_en) begin
            run_d = '0;
        end else if (run_q != RUN_MAX) begin
            run_d = run_q + RUN_W'(1);
        end
        if (run_d == RUN_MAX) begin
            err_d = 1'b1;
        end
    end

    assign deadlock_err = err_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_q;
    logic [CNT_W-1:0] flush_count_q;

    // Free-running performance counters, wrapping modulo 2^CNT_W
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (!pc_en) begin
                stall_cycles_q <= stall_cycles_q + CNT_W'(1);
            end
            if (flush_evt) begin
                flush_count_q <= flush_count_q + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`else
    logic unused_flush_evt;
    assign unused_flush_evt = flush_evt;
    assign stall_cycles     = '0;
    assign flush_count      = '0;
`endif

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Central stall/flush arbiter for the dual-issue 5-stage pipeline. It consumes the stall requests from the ID- and EX-stage forwarding units, the data-memory busy flag, branch redirects and exception requests. It produces per-stage pipeline-register enables and bubble-insert (flush) controls. Registered state tracks the post-exception drain, stall run length (deadlock watchdog) and performance counters.

Parameters:
STALL_TIMEOUT, 16, consecutive stall cycles at which deadlock_err is set (>=2)
FLUSH_CYCLES, 2, cycles IF/ID and ID/EX are held flushed after an exception (>=1)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
id_stall_req  in  1  OR of ID-stage forwarding-unit stall outputs
ex_stall_req  in  1  OR of EX-stage forwarding-unit stall outputs
mem_busy  in  1  data memory not ready; freezes whole pipe
branch_redirect  in  1  taken/mispredicted branch resolved in EX this cycle
exception_req  in  1  exception committed in MEM this cycle
pc_en  out  1  PC register enable
if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  pipeline register enables
if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load bubble (valid0=valid1=0) when enabled
ctrl_state  out  2  0=RUN, 1=STALL, 2=FLUSH
stall_cycles  out  CNT_W  count of cycles with pc_en=0
flush_count  out  CNT_W  count of redirect/exception events
deadlock_err  out  1  sticky watchdog error

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high.
- Outputs are combinational from inputs and registered state, with no added latency. Registered state updates on the rising clk edge.
- Reset: state=RUN, run counter=0, flush counter=0, stall_cycles=0, flush_count=0, deadlock_err=0.
- Control outputs while reset=1: all enables=1, all flushes=1. This loads bubbles.
- Priority, highest first, evaluated each cycle:
  1. mem_busy: all enables=0, all flushes=0. Pipe is frozen. Other requests are ignored and re-evaluated next cycle, because producers hold their requests.
  2. exception_req: all enables=1; if_id_flush=id_ex_flush=ex_mem_flush=1. Next state=FLUSH with flush counter=FLUSH_CYCLES-1. flush_count+1.
  3. state FLUSH: pc_en=1, all enables=1, if_id_flush=id_ex_flush=1, ex_mem_flush=0. id/ex stall requests and branch_redirect are ignored. The counter decrements each cycle; when it is 0 the next state is RUN.
  4. ex_stall_req: pc_en=if_id_en=id_ex_en=0; ex_mem_en=1 with ex_mem_flush=1; mem_wb_en=1. branch_redirect is ignored, since the branch is not yet resolved.
  5. branch_redirect: all enables=1; if_id_flush=id_ex_flush=1. flush_count+1.
  6. id_stall_req: pc_en=if_id_en=0; id_ex_en=1 with id_ex_flush=1; ex_mem_en=mem_wb_en=1.
  7. none: all enables=1, flushes=0, next state=RUN.
- STALL state: entered while rule 4 or 6 applies; returns to RUN on the first cycle neither applies.
- Run counter counts consecutive cycles with pc_en=0, including mem_busy cycles. It clears on any cycle with pc_en=1 and saturates at STALL_TIMEOUT.
  - deadlock_err is set on the cycle the counter reaches STALL_TIMEOUT.
  - deadlock_err is cleared only by reset.
- ctrl_state reports STALL for rules 1, 4 and 6 when not in FLUSH.
- stall_cycles increments on every cycle with pc_en=0. Counters wrap modulo 2^CNT_W.
- Exception during FLUSH restarts the counter at FLUSH_CYCLES-1.
- Reset asserted mid-FLUSH or mid-STALL returns to RUN the next cycle.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: stall_cycles and flush_count behave as above.
- Undefined: both counter registers are omitted and the outputs are tied to 0.
- Watchdog and deadlock_err are present in both builds.

Test Plan:
1. id_stall_req=1 for 1 cycle -> pc_en=0, if_id_en=0, id_ex_flush=1, ctrl_state=1; next cycle all enables=1, ctrl_state=0; stall_cycles=1.
2. ex_stall_req=1 and branch_redirect=1 together for 2 cycles, then branch_redirect alone -> first 2 cycles: ex_mem_flush=1, id_ex_en=0, no redirect flush; cycle 3: if_id_flush=id_ex_flush=1; flush_count=1.
3. exception_req pulse with FLUSH_CYCLES=2 -> cycle0: all three flushes=1; cycles 1-2: if_id_flush=id_ex_flush=1, ctrl_state=2, id_stall_req ignored; cycle 3: RUN.
4. mem_busy=1 with exception_req=1 for 3 cycles, then mem_busy=0 -> 3 cycles all enables=0, no flush; cycle 4: exception flush taken.
5. id_stall_req held 16 cycles with STALL_TIMEOUT=16 -> deadlock_err=1 after the 16th edge; stays 1 after release until reset.
6. reset asserted during FLUSH -> next cycle ctrl_state=0, counters=0, deadlock_err=0; while reset=1 all enables=1 and all flushes=1.
